// File: rtl/spi_trg_cmd_master.sv
// Mode-0 SPI command transmitter (CS/CLK/MOSI), MSB first, with a valid/ready
// word interface on the parallel side. Every output is a flop.
module spi_trg_cmd_master #(
   parameter int DATA_W   = 16,
   parameter int CLK_DIV  = 5,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2,
   parameter int GAP      = 4
) (
   input  logic              CLK50M,
   input  logic              RESET_N,
   input  logic [DATA_W-1:0] TX_DATA,
   input  logic              TX_VALID,
   output logic              TX_READY,
   output logic              BUSY,
   output logic              DONE,
   output logic              SPI_CS,
   output logic              SPI_CLK,
   output logic              SPI_MOSI
);

   localparam int MAX_A   = (CS_SETUP > CLK_DIV) ? CS_SETUP : CLK_DIV;
   localparam int MAX_B   = (CS_HOLD > GAP) ? CS_HOLD : GAP;
   localparam int MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CNT_W   = $clog2(MAX_CNT + 1);
   localparam int BIT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(CS_SETUP - 1);
   localparam logic [CNT_W-1:0] DIV_LD   = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(CS_HOLD - 1);
   localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'((GAP > 0) ? GAP - 1 : 0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [BIT_W-1:0] BIT_LD   = BIT_W'(DATA_W - 1);
   localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_SHIFT,
      S_HOLD,
      S_GAP
   } state_t;

   state_t              state, state_n;
   logic [CNT_W-1:0]    cnt, cnt_n;
   logic [BIT_W-1:0]    bit_cnt, bit_n;
   logic [DATA_W-1:0]   shreg, sh_n;
   logic                cs_n, clk_n, mosi_n, done_n, ready_n, busy_n;

   always_ff @(posedge CLK50M or negedge RESET_N) begin
      if (!RESET_N) begin
         state    <= S_IDLE;
         cnt      <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         SPI_CS   <= 1'b1;
         SPI_CLK  <= 1'b0;
         SPI_MOSI <= 1'b0;
         DONE     <= 1'b0;
         TX_READY <= 1'b0;
         BUSY     <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         bit_cnt  <= bit_n;
         shreg    <= sh_n;
         SPI_CS   <= cs_n;
         SPI_CLK  <= clk_n;
         SPI_MOSI <= mosi_n;
         DONE     <= done_n;
         TX_READY <= ready_n;
         BUSY     <= busy_n;
      end
   end

   // Outputs are computed from the next state so they change on the same edge
   // as the state register, keeping every output a plain flop.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      bit_n   = bit_cnt;
      sh_n    = shreg;
      cs_n    = SPI_CS;
      clk_n   = SPI_CLK;
      mosi_n  = SPI_MOSI;
      done_n  = 1'b0;
      unique case (state)
         S_IDLE: begin
            cs_n   = 1'b1;
            clk_n  = 1'b0;
            mosi_n = 1'b0;
            if (TX_VALID && TX_READY) begin
               state_n = S_SETUP;
               cnt_n   = SETUP_LD;
               sh_n    = TX_DATA;
               cs_n    = 1'b0;
               mosi_n  = TX_DATA[DATA_W-1];
            end
         end
         S_SETUP: begin
            if (cnt == '0) begin
               state_n = S_SHIFT;
               cnt_n   = DIV_LD;
               bit_n   = BIT_LD;
            end else begin
               cnt_n = cnt - CNT_ONE;
            end
         end
         S_SHIFT: begin
            if (cnt != '0) begin
               cnt_n = cnt - CNT_ONE;
            end else if (!SPI_CLK) begin
               clk_n = 1'b1;
               cnt_n = DIV_LD;
            end else if (bit_cnt == '0) begin
               clk_n   = 1'b0;
               state_n = S_HOLD;
               cnt_n   = HOLD_LD;
            end else begin
               // falling edge: present the next bit while the receiver is idle
               clk_n  = 1'b0;
               cnt_n  = DIV_LD;
               bit_n  = bit_cnt - BIT_ONE;
               sh_n   = shreg << 1;
               mosi_n = sh_n[DATA_W-1];
            end
         end
         S_HOLD: begin
            if (cnt == '0) begin
               cs_n   = 1'b1;
               mosi_n = 1'b0;
               done_n = 1'b1;
               if (GAP > 0) begin
                  state_n = S_GAP;
                  cnt_n   = GAP_LD;
               end else begin
                  state_n = S_IDLE;
               end
            end else begin
               cnt_n = cnt - CNT_ONE;
            end
         end
         S_GAP: begin
            if (cnt == '0) begin
               state_n = S_IDLE;
            end else begin
               cnt_n = cnt - CNT_ONE;
            end
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
      ready_n = (state_n == S_IDLE);
      busy_n  = (state_n != S_IDLE);
   end

endmodule

// File: tb/tb_spi_trg_cmd_master.sv
// Bench for spi_trg_cmd_master: two configurations driven with directed and random
// words; a frame-level model predicts each decoded word and the frame timing.
`timescale 1ns/1ps
module tb_spi_trg_cmd_master;

   localparam int A_W = 16, A_DIV = 5, A_SU = 2, A_HO = 2, A_GAP = 4;
   localparam int B_W = 8,  B_DIV = 1, B_SU = 2, B_HO = 2, B_GAP = 0;

   logic clk = 1'b0;
   always #10 clk = ~clk;

   logic           rst_a, rst_b, valid_a, valid_b;
   logic [A_W-1:0] data_a;
   logic [B_W-1:0] data_b;
   logic           rdy_a, busy_a, done_a, cs_a, sck_a, mosi_a;
   logic           rdy_b, busy_b, done_b, cs_b, sck_b, mosi_b;

   spi_trg_cmd_master #(
      .DATA_W(A_W), .CLK_DIV(A_DIV), .CS_SETUP(A_SU), .CS_HOLD(A_HO), .GAP(A_GAP)
   ) dut_a (
      .CLK50M(clk), .RESET_N(rst_a), .TX_DATA(data_a), .TX_VALID(valid_a),
      .TX_READY(rdy_a), .BUSY(busy_a), .DONE(done_a),
      .SPI_CS(cs_a), .SPI_CLK(sck_a), .SPI_MOSI(mosi_a)
   );

   spi_trg_cmd_master #(
      .DATA_W(B_W), .CLK_DIV(B_DIV), .CS_SETUP(B_SU), .CS_HOLD(B_HO), .GAP(B_GAP)
   ) dut_b (
      .CLK50M(clk), .RESET_N(rst_b), .TX_DATA(data_b), .TX_VALID(valid_b),
      .TX_READY(rdy_b), .BUSY(busy_b), .DONE(done_b),
      .SPI_CS(cs_b), .SPI_CLK(sck_b), .SPI_MOSI(mosi_b)
   );

   logic rstv [2], rdyv [2], busyv [2], donev [2], csv [2], sckv [2], mosiv [2];
   assign rstv[0]  = rst_a;  assign rstv[1]  = rst_b;
   assign rdyv[0]  = rdy_a;  assign rdyv[1]  = rdy_b;
   assign busyv[0] = busy_a; assign busyv[1] = busy_b;
   assign donev[0] = done_a; assign donev[1] = done_b;
   assign csv[0]   = cs_a;   assign csv[1]   = cs_b;
   assign sckv[0]  = sck_a;  assign sckv[1]  = sck_b;
   assign mosiv[0] = mosi_a; assign mosiv[1] = mosi_b;

   // frame-level reference model parameters
   int unsigned m_w [2]   = '{A_W, B_W};
   int unsigned m_div [2] = '{A_DIV, B_DIV};
   int unsigned m_su [2]  = '{A_SU, B_SU};
   int unsigned m_ho [2]  = '{A_HO, B_HO};
   int unsigned m_gap [2] = '{A_GAP, B_GAP};

   logic [15:0] exp_q0 [$], exp_q1 [$];
   int unsigned acc_q0 [$], acc_q1 [$];
   bit          exact_gap [2];

   int unsigned n_checks = 0, n_errors = 0;
   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- monitor: decodes the SPI bus and scores each frame
   logic        prev_cs [2], prev_sck [2], prev_rdy [2], had_frame [2], done_ok [2];
   int unsigned low_len [2], hi_len [2], lowrun [2], highrun [2], nbits [2], done_cyc [2];
   logic [15:0] word [2];

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (!rstv[i]) begin
            check("done_in_reset", 32'(donev[i]), 0);
            prev_cs[i] = 1'b1; prev_sck[i] = 1'b0; prev_rdy[i] = 1'b0;
            had_frame[i] = 1'b0; done_ok[i] = 1'b0;
            low_len[i] = 0; hi_len[i] = 0; lowrun[i] = 0; highrun[i] = 0; nbits[i] = 0;
            word[i] = '0;
         end else begin
            check("rdy_and_busy", 32'(rdyv[i] & busyv[i]), 0);
            if (csv[i]) check("sck_idle", 32'(sckv[i]), 0);
            if (donev[i]) check("done_at_cs_rise", 32'({prev_cs[i], csv[i]}), 1);
            if (prev_cs[i] && !csv[i]) begin
               if (had_frame[i]) begin
                  if (exact_gap[i]) check("cs_gap", hi_len[i], m_gap[i] + 1);
                  else check("cs_gap_min", 32'(hi_len[i] >= m_gap[i] + 1), 1);
               end
               low_len[i] = 0; lowrun[i] = 0; highrun[i] = 0; nbits[i] = 0; word[i] = '0;
            end
            if (!csv[i]) begin
               low_len[i]++;
               if (sckv[i] && !prev_sck[i]) begin
                  nbits[i]++;
                  word[i] = {word[i][14:0], mosiv[i]};
                  if (nbits[i] == 1) check("first_low", lowrun[i], m_su[i] + m_div[i]);
                  else check("sck_low", lowrun[i], m_div[i]);
                  highrun[i] = 1;
               end else if (!sckv[i] && prev_sck[i]) begin
                  check("sck_high", highrun[i], m_div[i]);
                  lowrun[i] = 1;
               end else if (sckv[i]) begin
                  highrun[i]++;
               end else begin
                  lowrun[i]++;
               end
            end else if (!prev_cs[i]) begin
               check("nbits", nbits[i], m_w[i]);
               check("cs_low_len", low_len[i], m_su[i] + m_w[i] * 2 * m_div[i] + m_ho[i]);
               check("cs_hold", lowrun[i], m_ho[i]);
               check("done_with_cs", 32'(donev[i]), 1);
               if ((i == 0 && exp_q0.size() == 0) || (i == 1 && exp_q1.size() == 0)) begin
                  check("unexpected_frame", 32'(word[i]), 32'h1_0000);
               end else begin
                  logic [15:0] e;
                  int unsigned a;
                  if (i == 0) begin e = exp_q0.pop_front(); a = acc_q0.pop_front(); end
                  else begin e = exp_q1.pop_front(); a = acc_q1.pop_front(); end
                  check("word", 32'(word[i]), 32'(e));
                  check("done_latency", cyc - a,
                        m_su[i] + m_w[i] * 2 * m_div[i] + m_ho[i] + 1);
               end
               had_frame[i] = 1'b1; done_ok[i] = 1'b1; done_cyc[i] = cyc; hi_len[i] = 1;
            end else begin
               hi_len[i]++;
            end
            if (rdyv[i] && !prev_rdy[i] && done_ok[i]) begin
               check("rdy_after_done", cyc - done_cyc[i], m_gap[i]);
               done_ok[i] = 1'b0;
            end
            prev_cs[i] = csv[i]; prev_sck[i] = sckv[i]; prev_rdy[i] = rdyv[i];
         end
      end
   end

   // ---------------- stimulus
   task automatic drive(input int i, input logic v, input logic [15:0] d);
      if (i == 0) begin valid_a = v; data_a = d; end
      else begin valid_b = v; data_b = d[B_W-1:0]; end
   endtask

   task automatic push(input int i, input logic [15:0] w);
      if (i == 0) begin exp_q0.push_back(w); acc_q0.push_back(cyc); end
      else begin exp_q1.push_back(w & 16'h00FF); acc_q1.push_back(cyc); end
   endtask

   // called at a negedge; when keep is set TX_VALID stays high for the next word
   task automatic send(input int i, input logic [15:0] w, input bit keep);
      int unsigned t = 0;
      while (!rdyv[i] && t < 1000) begin @(negedge clk); t++; end
      check("ready_wait", 32'(rdyv[i]), 1);
      if (!rdyv[i]) return;
      exact_gap[i] = (t > 0);
      drive(i, 1'b1, w);
      push(i, w);
      @(negedge clk);
      if (!keep) drive(i, 1'b0, '0);
   endtask

   task automatic wait_idle(input int i);
      int unsigned t = 0;
      while (busyv[i] && t < 2000) begin @(negedge clk); t++; end
      check("idle_wait", 32'(busyv[i]), 0);
      repeat (8) @(negedge clk);
   endtask

   task automatic rand_thread(input int i);
      for (int b = 0; b < 10; b++) begin
         int unsigned len = $urandom_range(1, 3);
         for (int j = 0; j < int'(len); j++) send(i, 16'($urandom), j < int'(len) - 1);
         repeat ($urandom_range(0, 30)) @(negedge clk);
      end
      wait_idle(i);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_a = 1'b0; rst_b = 1'b0;
      drive(0, 1'b0, '0); drive(1, 1'b0, '0);
      repeat (3) @(negedge clk);
      check("rst_cs", 32'(cs_a), 1);
      check("rst_sck", 32'(sck_a), 0);
      check("rst_mosi", 32'(mosi_a), 0);
      check("rst_rdy", 32'(rdy_a), 0);
      check("rst_busy", 32'(busy_a), 0);
      check("rst_cs_b", 32'(cs_b), 1);
      rst_a = 1'b1; rst_b = 1'b1;
      check("rdy_before_edge", 32'(rdy_a), 0);
      @(negedge clk);
      check("rdy_after_release", 32'(rdy_a), 1);
      check("rdy_after_release_b", 32'(rdy_b), 1);

      send(0, 16'hA5C3, 1'b0); wait_idle(0);
      send(1, 16'h0081, 1'b0); wait_idle(1);

      send(0, 16'h0001, 1'b1); send(0, 16'hFFFF, 1'b0); wait_idle(0);

      // word offered while a frame is shifting must be ignored
      send(0, 16'h00FF, 1'b0);
      repeat (A_SU + 8 * A_DIV) @(negedge clk);
      check("rdy_low_in_frame", 32'(rdy_a), 0);
      drive(0, 1'b1, 16'h1234);
      @(negedge clk);
      check("rdy_low_ignored", 32'(rdy_a), 0);
      drive(0, 1'b0, '0);
      wait_idle(0);
      check("no_extra_frame", exp_q0.size(), 0);

      // abort in the eighth bit by asynchronous reset
      send(0, 16'($urandom), 1'b0);
      repeat (A_SU + 7 * 2 * A_DIV + 1) @(negedge clk);
      check("frame_active", 32'(cs_a), 0);
      #5 rst_a = 1'b0;
      exp_q0.delete(); acc_q0.delete();
      #1;
      check("abort_cs", 32'(cs_a), 1);
      check("abort_sck", 32'(sck_a), 0);
      check("abort_mosi", 32'(mosi_a), 0);
      check("abort_busy", 32'(busy_a), 0);
      check("abort_done", 32'(done_a), 0);
      repeat (2) @(negedge clk);
      rst_a = 1'b1;
      check("abort_rdy_release", 32'(rdy_a), 0);
      @(negedge clk);
      check("abort_rdy_next", 32'(rdy_a), 1);
      send(0, 16'hBEEF, 1'b0); wait_idle(0);

      send(1, 16'h003C, 1'b1); send(1, 16'h00C3, 1'b0); wait_idle(1);

      fork
         rand_thread(0);
         rand_thread(1);
      join

      check("queue_a_empty", exp_q0.size(), 0);
      check("queue_b_empty", exp_q1.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
